// File: rtl/cgate21_pkg.sv
// Shared types and helpers for the cgate21 pipeline: function select encoding,
// per-lane complex-gate evaluation and population count.
package cgate21_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int POP_W     = $clog2(MAX_WIDTH + 1);

    typedef enum logic [1:0] {
        OAI21 = 2'b00,
        AOI21 = 2'b01,
        OA21  = 2'b10,
        AO21  = 2'b11
    } mode_e;

    // Evaluated at the widest lane count; callers zero-extend and truncate.
    function automatic logic [MAX_WIDTH-1:0] cgate_eval(
        input mode_e                mode,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic [MAX_WIDTH-1:0] c
    );
        logic [MAX_WIDTH-1:0] res;
        case (mode)
            OAI21:   res = ~((a | b) & c);
            AOI21:   res = ~((a & b) | c);
            OA21:    res = (a | b) & c;
            default: res = (a & b) | c;
        endcase
        return res;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cgate21_slice.sv
// One elastic register slice: holds a word plus its valid bit and accepts a
// new word whenever it is empty or its current word leaves in the same cycle.
module cgate21_slice
    import cgate21_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         r,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Ready passes straight through so a full chain can drain and fill together.
    assign up_ready = ~valid_q | dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/cgate21_pipe.sv
// WIDTH-lane selectable 21-type complex gate feeding an elastic pipeline of
// STAGES slices, with a saturating counter of output bit toggles.
module cgate21_pipe
    import cgate21_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
);

    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] front_data;
    logic [STAGES:0]  chain_valid;
    logic [STAGES:0]  chain_ready;
    logic [WIDTH-1:0] chain_data [STAGES+1];

    assign front_data = WIDTH'(cgate_eval(mode_e'(mode), MAX_WIDTH'(a),
                                          MAX_WIDTH'(b), MAX_WIDTH'(c)));

    assign chain_valid[0]      = in_valid;
    assign chain_data[0]       = front_data;
    assign in_ready            = chain_ready[0];
    assign chain_ready[STAGES] = out_ready;
    assign out_valid           = chain_valid[STAGES];
    assign y                   = chain_data[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cgate21_slice #(.W(WIDTH)) u_slice (
            .clk      (clk),
            .r        (r),
            .up_valid (chain_valid[k]),
            .up_ready (chain_ready[k]),
            .up_data  (chain_data[k]),
            .dn_valid (chain_valid[k+1]),
            .dn_ready (chain_ready[k+1]),
            .dn_data  (chain_data[k+1])
        );
    end

    logic             out_xfer;
    logic [WIDTH-1:0] last_y;
    logic [POP_W-1:0] toggles;
    logic [SUM_W-1:0] sum;

    assign out_xfer = out_valid & out_ready;
    assign toggles  = popcount(MAX_WIDTH'(y ^ last_y));
    assign sum      = SUM_W'(toggle_cnt) + SUM_W'(toggles);

    // A clear drops the coincident transfer's toggles, but last_y still tracks it.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            last_y     <= '0;
            toggle_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            if (out_xfer) begin
                last_y <= y;
            end
            if (cnt_clr) begin
                toggle_cnt <= '0;
                cnt_sat    <= 1'b0;
            end else if (out_xfer) begin
                if (sum >= CNT_MAX) begin
                    toggle_cnt <= '1;
                    cnt_sat    <= 1'b1;
                end else begin
                    toggle_cnt <= sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_cgate21_pipe.sv
// Directed and randomized checks of cgate21_pipe against a word-level model.
module tb_cgate21_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared directed-test stimulus (main and saturation instances)
    logic       r;
    logic       in_valid;
    logic [7:0] a, b, c;
    logic [1:0] mode;
    logic       out_ready;
    logic       cnt_clr;

    logic        m_in_ready, m_out_valid, m_sat;
    logic [7:0]  m_y;
    logic [15:0] m_cnt;
    logic        s_in_ready, s_out_valid, s_sat;
    logic [7:0]  s_y;
    logic [3:0]  s_cnt;

    // randomized instances (STAGES=1 and STAGES=4)
    logic [1:0]  p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_sat;
    logic [7:0]  pa, pb, pc;
    logic [1:0]  pmode;
    logic [7:0]  p_y0, p_y1;
    logic [15:0] p_cnt0, p_cnt1;

    cgate21_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_main (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .y(m_y), .out_valid(m_out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .toggle_cnt(m_cnt), .cnt_sat(m_sat));

    cgate21_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_sat (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .y(s_y), .out_valid(s_out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .toggle_cnt(s_cnt), .cnt_sat(s_sat));

    cgate21_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u_s1 (
        .clk(clk), .r(r), .in_valid(p_in_valid[0]), .in_ready(p_in_ready[0]),
        .a(pa), .b(pb), .c(pc), .mode(pmode), .y(p_y0), .out_valid(p_out_valid[0]),
        .out_ready(p_out_ready[0]), .cnt_clr(1'b0), .toggle_cnt(p_cnt0), .cnt_sat(p_sat[0]));

    cgate21_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(16)) u_s4 (
        .clk(clk), .r(r), .in_valid(p_in_valid[1]), .in_ready(p_in_ready[1]),
        .a(pa), .b(pb), .c(pc), .mode(pmode), .y(p_y1), .out_valid(p_out_valid[1]),
        .out_ready(p_out_ready[1]), .cnt_clr(1'b0), .toggle_cnt(p_cnt1), .cnt_sat(p_sat[1]));

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    localparam int N_RND    = 10000;
    localparam int RND_BUDG = 60000;

    int         sent [2];
    int         rcvd [2];
    int         mcnt [2];
    logic [7:0] mlast[2];

    function automatic logic [7:0] ref_eval(input logic [1:0] m, input logic [7:0] av,
                                            input logic [7:0] bv, input logic [7:0] cv);
        case (m)
            2'd0:    return ~((av | bv) & cv);
            2'd1:    return ~((av & bv) | cv);
            2'd2:    return (av | bv) & cv;
            default: return (av & bv) | cv;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present one word with out_ready=1, wait for it to leave; yv is Y at that transfer.
    task automatic send_drain(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                              input logic [7:0] cv, output logic [7:0] yv);
        int n;
        @(negedge clk);
        mode = m; a = av; b = bv; c = cv; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!m_in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_wait", 32'(n < 20), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!m_out_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("drain_wait", 32'(n < 20), 1);
        yv = m_y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        r = 1'b1;
    endtask

    task automatic rnd_side(input int k);
        logic [7:0] e, yv;
        int         pc_t;
        yv = (k == 0) ? p_y0 : p_y1;
        if (p_in_valid[k] && p_in_ready[k]) begin
            if (k == 0) exp_q0.push_back(ref_eval(pmode, pa, pb, pc));
            else        exp_q1.push_back(ref_eval(pmode, pa, pb, pc));
            sent[k]++;
        end
        if (p_out_valid[k] && p_out_ready[k]) begin
            chk($sformatf("rnd_nonempty%0d", k), 32'(((k == 0) ? exp_q0.size() : exp_q1.size()) > 0), 1);
            if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else e = 8'h00;
            chk($sformatf("rnd_y%0d", k), 32'(yv), 32'(e));
            pc_t     = $countones(e ^ mlast[k]);
            mlast[k] = e;
            mcnt[k]  = (mcnt[k] + pc_t > 65535) ? 65535 : mcnt[k] + pc_t;
            rcvd[k]++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] yv;
        logic [7:0] tt_exp [4];
        int         acc, scnt, cycles;
        logic       ssat;
        logic [7:0] slast, v;

        r = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; mode = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        p_in_valid = '0; p_out_ready = '0; pa = '0; pb = '0; pc = '0; pmode = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(m_out_valid), 0);
        chk("rst_y", 32'(m_y), 0);
        chk("rst_cnt", 32'(m_cnt), 0);
        chk("rst_sat", 32'(m_sat), 0);
        @(negedge clk);
        r = 1'b1;
        #1;
        chk("rst_in_ready", 32'(m_in_ready), 1);

        // reset mid-stream with two words in flight
        @(negedge clk);
        in_valid = 1'b1; mode = 2'd2; a = 8'hF0; b = 8'hCC; c = 8'hAA;
        @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        r = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(m_out_valid), 0);
        chk("mid_rst_y", 32'(m_y), 0);
        chk("mid_rst_cnt", 32'(m_cnt), 0);
        @(negedge clk);
        r = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(m_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("mid_rst_no_stale", 32'(m_out_valid), 0);
        end

        // truth table and latency
        tt_exp[0] = 8'h57; tt_exp[1] = 8'h15; tt_exp[2] = 8'hA8; tt_exp[3] = 8'hEA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 2'(i); a = 8'hF0; b = 8'hCC; c = 8'hAA;
            #1;
            chk("tt_in_ready", 32'(m_in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("tt_early", 32'(m_out_valid), 0);
            @(negedge clk); #1;
            chk("tt_valid", 32'(m_out_valid), 1);
            chk($sformatf("tt_y_mode%0d", i), 32'(m_y), 32'(tt_exp[i]));
        end

        // full stall: two words buffered, Y frozen, then in-order drain
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1; mode = 2'(acc); a = 8'(acc * 17 + 3); b = 8'h5A ^ 8'(acc); c = 8'h3C + 8'(acc);
            #1;
            if (k >= 2) begin
                chk("stall_valid", 32'(m_out_valid), 1);
                chk("stall_y_frozen", 32'(m_y), 32'(exp_q[0]));
            end
            if (m_in_ready) begin
                exp_q.push_back(ref_eval(mode, a, b, c));
                acc++;
            end
        end
        chk("stall_accepted", 32'(acc), 2);
        @(negedge clk); #1;
        chk("stall_in_ready", 32'(m_in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("drain0_valid", 32'(m_out_valid), 1);
        chk("drain0_y", 32'(m_y), 32'(exp_q.pop_front()));
        @(negedge clk); #1;
        chk("drain1_valid", 32'(m_out_valid), 1);
        chk("drain1_y", 32'(m_y), 32'(exp_q.pop_front()));
        @(negedge clk); #1;
        chk("drain_empty", 32'(m_out_valid), 0);

        // toggle counting: 00, FF, 0F
        do_reset();
        send_drain(2'd3, 8'h00, 8'h00, 8'h00, yv);
        chk("tog_y0", 32'(yv), 32'h00);
        @(negedge clk); #1;
        chk("tog_cnt0", 32'(m_cnt), 0);
        send_drain(2'd3, 8'h00, 8'h00, 8'hFF, yv);
        chk("tog_y1", 32'(yv), 32'hFF);
        @(negedge clk); #1;
        chk("tog_cnt1", 32'(m_cnt), 8);
        send_drain(2'd3, 8'h00, 8'h00, 8'h0F, yv);
        chk("tog_y2", 32'(yv), 32'h0F);
        @(negedge clk); #1;
        chk("tog_cnt2", 32'(m_cnt), 12);

        // saturation on the 4-bit counter, then clear with a coincident transfer
        do_reset();
        scnt = 0; ssat = 1'b0; slast = 8'h00;
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 1) ? 8'hFF : 8'h00;
            send_drain(2'd3, 8'h00, 8'h00, v, yv);
            if (scnt + $countones(v ^ slast) >= 15) begin
                scnt = 15; ssat = 1'b1;
            end else begin
                scnt = scnt + $countones(v ^ slast);
            end
            slast = v;
            @(negedge clk); #1;
            chk($sformatf("sat_cnt%0d", i), 32'(s_cnt), 32'(scnt));
            chk($sformatf("sat_flag%0d", i), 32'(s_sat), 32'(ssat));
        end
        send_drain(2'd3, 8'h00, 8'h00, 8'h00, yv);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_cnt", 32'(s_cnt), 0);
        chk("clr_sat", 32'(s_sat), 0);
        send_drain(2'd3, 8'h00, 8'h00, 8'hFF, yv);
        @(negedge clk); #1;
        chk("clr_last_y_kept", 32'(s_cnt), 8);

        // randomized backpressure on STAGES=1 and STAGES=4
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; rcvd[k] = 0; mcnt[k] = 0; mlast[k] = 8'h00;
        end
        cycles = 0;
        while ((rcvd[0] < N_RND || rcvd[1] < N_RND) && cycles < RND_BUDG) begin
            @(negedge clk);
            cycles++;
            chk("rnd_cnt0", 32'(p_cnt0), 32'(mcnt[0]));
            chk("rnd_cnt1", 32'(p_cnt1), 32'(mcnt[1]));
            pa = 8'($urandom); pb = 8'($urandom); pc = 8'($urandom); pmode = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                p_in_valid[k]  = (sent[k] < N_RND) && ($urandom_range(0, 3) != 0);
                p_out_ready[k] = ($urandom_range(0, 3) != 0);
            end
            #1;
            rnd_side(0);
            rnd_side(1);
        end
        chk("rnd_budget", 32'(cycles < RND_BUDG), 1);
        chk("rnd_rcvd0", 32'(rcvd[0]), N_RND);
        chk("rnd_rcvd1", 32'(rcvd[1]), N_RND);
        @(negedge clk);
        p_in_valid = '0; p_out_ready = '0;
        #1;
        chk("rnd_final_cnt0", 32'(p_cnt0), 32'(mcnt[0]));
        chk("rnd_final_cnt1", 32'(p_cnt1), 32'(mcnt[1]));
        chk("rnd_final_sat0", 32'(p_sat[0]), 32'(mcnt[0] == 65535));
        chk("rnd_final_sat1", 32'(p_sat[1]), 32'(mcnt[1] == 65535));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
